// File: rtl/ram_pkg.sv
// ============================================================================
// Module : ram_pkg
// Brief  : Shared types and defaults for the dual-port clearable RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 3;

    // Number of words for a given address width.
    function automatic int words(input int depth);
        return 2 ** depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_clear_seq.sv
// ============================================================================
// Module : ram_clear_seq
// Brief  : Clear sequencer that sweeps every address after reset or on request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    output logic             o_clr_we,
    output logic [DEPTH-1:0] o_clr_addr,
    output logic             o_run,
    output logic             o_ready
);

    localparam logic [DEPTH-1:0] C_LAST = {DEPTH{1'b1}};

    state_t           r_state;
    logic [DEPTH-1:0] r_cnt;
    logic             r_ready;

    // The counter is only DEPTH bits wide; the sweep ends on the compare with
    // the last address, so its wrap back to zero is never observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_we   = (r_state == ST_CLEAR);
    assign o_clr_addr = r_cnt;
    assign o_run      = (r_state == ST_RUN);
    assign o_ready    = r_ready;

endmodule

`default_nettype wire

// File: rtl/ram_dp_clr.sv
// ============================================================================
// Module : ram_dp_clr
// Brief  : RAM with a read/write port A, a read-only port B and a clear sweep.
//          Define RAM_BYPASS_EN for write-first behaviour on both ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int                 WIDTH     = DEFAULT_WIDTH,
    parameter int                 DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0]   CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [DEPTH-1:0] address,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    input  logic [DEPTH-1:0] address_b,
    output logic [WIDTH-1:0] out_b,
    output logic             ready
);

    localparam int C_WORDS = words(DEPTH);

`ifdef RAM_BYPASS_EN
    localparam bit C_BYPASS = 1'b1;
`else
    localparam bit C_BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] r_mem [C_WORDS];
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_out_b;

    logic             w_clr_we;
    logic [DEPTH-1:0] w_clr_addr;
    logic             w_run;
    logic             w_we;
    logic [DEPTH-1:0] w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_port_we;

    ram_clear_seq #(
        .DEPTH (DEPTH)
    ) u_seq (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (clear),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_run      (w_run),
        .o_ready    (ready)
    );

    // Reset suppresses every write in its cycle, including a pending load.
    assign w_port_we = w_run & load;
    assign w_we      = ~reset & (w_clr_we | w_port_we);
    assign w_waddr   = w_clr_we ? w_clr_addr : address;
    assign w_wdata   = w_clr_we ? CLEAR_VAL : in;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_run) begin
            r_out   <= '0;
            r_out_b <= '0;
        end else begin
            r_out   <= (C_BYPASS && load) ? in : r_mem[address];
            r_out_b <= (C_BYPASS && load && (address == address_b)) ? in : r_mem[address_b];
        end
    end

    assign out   = r_out;
    assign out_b = r_out_b;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
// ============================================================================
// Module : tb_ram_dp_clr
// Brief  : Scoreboard bench for ram_dp_clr against an array-based reference.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_dp_clr;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;
    localparam int WORDS = 8;

`ifdef RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic             load = 1'b0;
    logic [DEPTH-1:0] address = '0;
    logic [WIDTH-1:0] in = '0;
    logic [WIDTH-1:0] out;
    logic [DEPTH-1:0] address_b = '0;
    logic [WIDTH-1:0] out_b;
    logic             ready;

    ram_dp_clr #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .CLEAR_VAL (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .address   (address),
        .in        (in),
        .out       (out),
        .address_b (address_b),
        .out_b     (out_b),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             rdy;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;

    // Reference: word array plus the number of sweep cycles still to run.
    logic [WIDTH-1:0] m_mem [WORDS];
    int               m_sweep = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every output set is due exactly one edge after it was issued.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cycle) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.due < cycle) begin
                bad++;
                $display("FAIL stale_entry due=%0d cycle=%0d", e.due, cycle);
            end else if (out !== e.a || out_b !== e.b || ready !== e.rdy) begin
                bad++;
                $display("FAIL cycle=%0d out=%h/%h out_b=%h/%h ready=%b/%b (actual/required)",
                         cycle, out, e.a, out_b, e.b, ready, e.rdy);
            end
        end
    end

    task automatic step(input logic rst, input logic clr, input logic ld,
                        input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d,
                        input logic [DEPTH-1:0] ab);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; clear = clr; load = ld; address = a; in = d; address_b = ab;
        e.due = cycle + 1;
        e.a = '0;
        e.b = '0;
        if (rst) begin
            m_sweep = WORDS;
        end else if (m_sweep > 0) begin
            m_sweep--;
        end else begin
            e.a = (BYP && ld) ? d : m_mem[a];
            e.b = (BYP && ld && a == ab) ? d : m_mem[ab];
            if (ld) m_mem[a] = d;
            if (clr) m_sweep = WORDS;
        end
        if (m_sweep == WORDS) begin
            for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        end
        e.rdy = (m_sweep == 0);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'(i), '0, 3'(WORDS - 1 - i));
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) m_mem[i] = 16'hXXXX;

        // Reset, sweep, then read every word on both ports.
        step(1, 0, 0, 0, 0, 0);
        idle(8);
        for (int i = 0; i < WORDS; i++) step(0, 0, 0, 3'(i), 16'h5555, 3'(i));

        // Port A read-first write, then read back.
        step(0, 0, 1, 3'd5, 16'h1234, 3'd0);
        step(0, 0, 0, 3'd5, 16'h0000, 3'd5);

        // Concurrent write and port B read of the same word.
        step(0, 0, 1, 3'd2, 16'hBEEF, 3'd2);
        step(0, 0, 0, 3'd2, 16'h0000, 3'd2);

        // Fill with ones, clear, loads during the sweep are dropped.
        for (int i = 0; i < WORDS; i++) step(0, 0, 1, 3'(i), 16'hFFFF, 3'(i));
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < WORDS; i++) step(0, 0, 1, 3'(i), 16'hA5A5, 3'(i));
        for (int i = 0; i < WORDS; i++) step(0, 0, 0, 3'(i), 0, 3'(WORDS - 1 - i));

        // Reset at sweep cycle 4 restarts the sweep.
        step(0, 1, 0, 0, 0, 0);
        idle(4);
        step(1, 0, 0, 0, 0, 0);
        idle(8);
        idle(2);

        // Reset, clear and load together: reset wins, the load is discarded.
        step(0, 0, 1, 3'd1, 16'h7777, 3'd1);
        step(1, 1, 1, 3'd1, 16'h00AA, 3'd1);
        idle(8);
        step(0, 0, 0, 3'd1, 0, 3'd1);

        // Randomised traffic with occasional clear or reset.
        for (int i = 0; i < 400; i++) begin
            logic r, c;
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 59) == 0);
            step(r, c, 1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 3'($urandom));
        end
        idle(10);

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain left=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
